// File: rtl/counter_sequencer_pkg.sv
// Shared definitions for the counter sequencer: state encoding, the smallest
// legal period, and the step-index width derivation.
package counter_sequencer_pkg;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2
    } seq_state_e;

    // Periods below this are stored as this value.
    localparam int unsigned MIN_PERIOD = 2;

    // Step index width; a single-entry table still needs one bit.
    function automatic int unsigned step_width(input int unsigned steps);
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

endpackage

// File: rtl/counter_with_strobe.sv
// Event counter with terminal strobe and enable pacing.
//   clk, rst     : clock, synchronous active-high reset (clears count)
//   enable       : count one event; legal only while ready is high
//   reset_value  : period; strobe after this many enables, then restart
//   strobe       : one-cycle pulse in the cycle after the terminal enable
//   ready        : high once LATENCY idle cycles have passed since the last
//                  enable or reset
module counter_with_strobe #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned LATENCY = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [WIDTH-1:0] reset_value,
    output logic             strobe,
    output logic             ready
);

    localparam int unsigned CW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

    logic [WIDTH-1:0] count;
    logic [CW-1:0]    cooldown;
    logic             terminal;

    // Greater-or-equal keeps a shrunk period from running past its end.
    assign terminal = (count >= (reset_value - WIDTH'(1)));
    assign ready    = (cooldown == '0);

    // Count, self-reload and pacing.
    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= '0;
            cooldown <= CW'(LATENCY);
            strobe   <= 1'b0;
        end else begin
            strobe <= 1'b0;
            if (enable) begin
                cooldown <= CW'(LATENCY);
                if (terminal) begin
                    count  <= '0;
                    strobe <= 1'b1;
                end else begin
                    count <= count + WIDTH'(1);
                end
            end else if (cooldown != '0) begin
                cooldown <= cooldown - CW'(1);
            end
        end
    end

endmodule

// File: rtl/counter_sequencer.sv
// Runs a counter_with_strobe through a table of STEPS periods, turning event
// ticks into paced enables and reporting step and sequence completion.
//   clk, rst            : clock, synchronous active-high reset
//   cfg_we/addr/data    : period table write port (values < 2 stored as 2)
//   start, stop         : begin at step 0 (IDLE only) / abort (CLEAR, RUN)
//   loop_en             : at the last step's strobe, restart at step 0
//   tick                : event to be counted
//   busy                : not IDLE
//   step                : current step index
//   step_done, seq_done : completion pulses, valid in the strobe cycle
//   overrun             : sticky, a tick was dropped; cleared by start
module counter_sequencer
    import counter_sequencer_pkg::*;
#(
    parameter  int unsigned WIDTH   = 8,
    parameter  int unsigned LATENCY = 4,
    parameter  int unsigned STEPS   = 4,
    localparam int unsigned SW      = step_width(STEPS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [SW-1:0]    cfg_addr,
    input  logic [WIDTH-1:0] cfg_data,
    input  logic             start,
    input  logic             stop,
    input  logic             loop_en,
    input  logic             tick,
    output logic             busy,
    output logic [SW-1:0]    step,
    output logic             step_done,
    output logic             seq_done,
    output logic             overrun
);

    seq_state_e       state;
    logic [WIDTH-1:0] tbl [STEPS];
    logic [WIDTH-1:0] cur_period;
    logic [WIDTH-1:0] cfg_value;
    logic             pending;
    logic             last_step;
    logic [SW-1:0]    next_step;

    logic ctr_rst;
    logic ctr_enable;
    logic ctr_strobe;
    logic ctr_ready;

    assign cfg_value = (cfg_data < WIDTH'(MIN_PERIOD)) ? WIDTH'(MIN_PERIOD) : cfg_data;
    assign last_step = (step == SW'(STEPS - 1));
    assign next_step = last_step ? '0 : step + SW'(1);

    // Counter gating; the counter's own pacing keeps enable off in the
    // cycle after ctr_rst and in every strobe cycle.
    assign ctr_rst    = rst || (state == ST_CLEAR);
    assign ctr_enable = (state == ST_RUN) && pending && ctr_ready && !stop;

    assign busy      = (state != ST_IDLE);
    assign step_done = (state == ST_RUN) && ctr_strobe && !stop;
    assign seq_done  = step_done && last_step && !loop_en;

    // Sequencer state, step tracking, tick buffering and period table.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            step       <= '0;
            pending    <= 1'b0;
            overrun    <= 1'b0;
            cur_period <= WIDTH'(MIN_PERIOD);
            for (int unsigned i = 0; i < STEPS; i++) begin
                tbl[i] <= WIDTH'(MIN_PERIOD);
            end
        end else begin
            // Table loads below read the pre-write value on a same-cycle write.
            if (cfg_we) begin
                tbl[cfg_addr] <= cfg_value;
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_CLEAR;
                        step       <= '0;
                        cur_period <= tbl[0];
                        pending    <= 1'b0;
                        overrun    <= 1'b0;
                    end
                end

                ST_CLEAR: begin
                    if (stop) begin
                        state   <= ST_IDLE;
                        pending <= 1'b0;
                    end else begin
                        state <= ST_RUN;
                        if (tick) begin
                            pending <= 1'b1;
                            if (pending) begin
                                overrun <= 1'b1;
                            end
                        end
                    end
                end

                ST_RUN: begin
                    if (stop) begin
                        state   <= ST_IDLE;
                        pending <= 1'b0;
                    end else begin
                        // A tick alongside an enable refills the buffer.
                        if (tick) begin
                            pending <= 1'b1;
                        end else if (ctr_enable) begin
                            pending <= 1'b0;
                        end
                        if (tick && pending && !ctr_enable) begin
                            overrun <= 1'b1;
                        end
                        // Strobe cycle: the only point where the period changes.
                        if (ctr_strobe) begin
                            step       <= next_step;
                            cur_period <= tbl[next_step];
                            if (last_step && !loop_en) begin
                                state <= ST_IDLE;
                            end
                        end
                    end
                end

                default: begin
                    state   <= ST_IDLE;
                    pending <= 1'b0;
                end
            endcase
        end
    end

    counter_with_strobe #(
        .WIDTH   (WIDTH),
        .LATENCY (LATENCY)
    ) u_ctr (
        .clk         (clk),
        .rst         (ctr_rst),
        .enable      (ctr_enable),
        .reset_value (cur_period),
        .strobe      (ctr_strobe),
        .ready       (ctr_ready)
    );

endmodule

// File: tb/tb_counter_sequencer.sv
// Scoreboard bench for counter_sequencer: stimulus queues the expected
// step_done events, a negedge monitor pops and compares them.
module tb_counter_sequencer;

    localparam int unsigned WIDTH   = 8;
    localparam int unsigned LATENCY = 4;
    localparam int unsigned STEPS   = 4;
    localparam int unsigned SW      = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_we;
    logic [SW-1:0]    cfg_addr;
    logic [WIDTH-1:0] cfg_data;
    logic             start;
    logic             stop;
    logic             loop_en;
    logic             tick;
    logic             busy;
    logic [SW-1:0]    step;
    logic             step_done;
    logic             seq_done;
    logic             overrun;

    typedef struct packed {
        logic [SW-1:0] step;
        logic          seq;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   sd_count = 0;
    int   en_count = 0;
    int   cyc      = 0;
    int   last_en  = -1;
    bit   spacing_chk = 1'b0;

    counter_sequencer #(
        .WIDTH   (WIDTH),
        .LATENCY (LATENCY),
        .STEPS   (STEPS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .start     (start),
        .stop      (stop),
        .loop_en   (loop_en),
        .tick      (tick),
        .busy      (busy),
        .step      (step),
        .step_done (step_done),
        .seq_done  (seq_done),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: score every step_done against the queue, time the enables.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (step_done) begin
                sd_count++;
                if (exp_q.size() == 0) begin
                    check("unexpected_step_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("sd_step", int'(step), int'(e.step));
                    check("sd_seq_done", int'(seq_done), int'(e.seq));
                end
            end else if (seq_done) begin
                check("seq_done_without_step_done", 1, 0);
            end
            if (dut.ctr_enable) begin
                en_count++;
                if (spacing_chk && last_en >= 0) begin
                    check("enable_gap", cyc - last_en, LATENCY + 1);
                end
                last_en = cyc;
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int s, input bit q);
        exp_t e;
        e.step = SW'(s);
        e.seq  = q;
        exp_q.push_back(e);
    endtask

    task automatic push_seq4();
        for (int i = 0; i < 4; i++) push_exp(i, i == 3);
    endtask

    task automatic cfg_write(input int a, input int d);
        cfg_we   = 1'b1;
        cfg_addr = SW'(a);
        cfg_data = WIDTH'(d);
        cycle();
        cfg_we   = 1'b0;
    endtask

    task automatic cfg_table(input int d0, input int d1, input int d2, input int d3);
        cfg_write(0, d0);
        cfg_write(1, d1);
        cfg_write(2, d2);
        cfg_write(3, d3);
    endtask

    task automatic do_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        cycle();
        stop = 1'b0;
    endtask

    task automatic ticks(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            cycle();
            tick = 1'b0;
            repeat (gap - 1) cycle();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int  sd0;
        int  en0;
        bit  found;

        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        start = 1'b0; stop = 1'b0; loop_en = 1'b0; tick = 1'b0;

        // Reset state
        repeat (3) cycle();
        @(negedge clk);
        check("ctr_rst_in_reset", int'(dut.ctr_rst), 1);
        cycle();
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_step", int'(step), 0);
        check("rst_step_done", int'(step_done), 0);
        check("rst_seq_done", int'(seq_done), 0);
        check("rst_overrun", int'(overrun), 0);

        // Basic run: {3,2,5,4}, a tick every 8 cycles
        cfg_table(3, 2, 5, 4);
        push_seq4();
        sd0 = sd_count;
        do_start();
        @(negedge clk);
        check("basic_busy_clear", int'(busy), 1);
        check("basic_ctr_rst_clear", int'(dut.ctr_rst), 1);
        ticks(3, 8);
        check("basic_sd_after3", sd_count - sd0, 1);
        ticks(2, 8);
        check("basic_sd_after5", sd_count - sd0, 2);
        ticks(5, 8);
        check("basic_sd_after10", sd_count - sd0, 3);
        ticks(4, 8);
        check("basic_sd_after14", sd_count - sd0, 4);
        check("basic_busy_end", int'(busy), 0);
        check("basic_overrun", int'(overrun), 0);
        check("basic_queue_empty", exp_q.size(), 0);

        // Loop: all periods 2, 20 ticks -> 10 steps, wrap, no seq_done
        cfg_table(2, 2, 2, 2);
        loop_en = 1'b1;
        for (int i = 0; i < 10; i++) push_exp(i % 4, 1'b0);
        sd0 = sd_count;
        do_start();
        ticks(20, 8);
        check("loop_sd_count", sd_count - sd0, 10);
        check("loop_busy", int'(busy), 1);
        check("loop_step", int'(step), 2);
        do_stop();
        loop_en = 1'b0;
        @(negedge clk);
        check("loop_stop_busy", int'(busy), 0);
        check("loop_queue_empty", exp_q.size(), 0);

        // Overrun: tick every cycle from the first RUN cycle
        cfg_table(3, 2, 5, 4);
        push_seq4();
        sd0 = sd_count;
        en0 = en_count;
        last_en = -1;
        spacing_chk = 1'b1;
        do_start();
        cycle();
        tick = 1'b1;
        cycle();
        @(negedge clk);
        check("ovr_after_first_tick", int'(overrun), 0);
        cycle();
        @(negedge clk);
        check("ovr_after_second_tick", int'(overrun), 1);
        for (int i = 0; i < 200 && busy; i++) cycle();
        check("ovr_reaches_idle", int'(busy), 0);
        tick = 1'b0;
        spacing_chk = 1'b0;
        check("ovr_sd_count", sd_count - sd0, 4);
        check("ovr_en_count", en_count - en0, 14);
        check("ovr_sticky", int'(overrun), 1);
        check("ovr_queue_empty", exp_q.size(), 0);

        // Stop mid-step: period 5, stop after 3 enables, tick alongside stop
        cfg_write(0, 5);
        do_start();
        @(negedge clk);
        check("ovr_cleared_by_start", int'(overrun), 0);
        sd0 = sd_count;
        en0 = en_count;
        ticks(3, 8);
        check("stop_en_count", en_count - en0, 3);
        tick = 1'b1;
        stop = 1'b1;
        cycle();
        tick = 1'b0;
        stop = 1'b0;
        @(negedge clk);
        check("stop_busy", int'(busy), 0);
        check("stop_pending", int'(dut.pending), 0);
        check("stop_overrun", int'(overrun), 0);
        check("stop_no_sd", sd_count - sd0, 0);
        push_exp(0, 1'b0);
        do_start();
        ticks(4, 8);
        check("restart_sd_after4", sd_count - sd0, 0);
        ticks(1, 8);
        check("restart_sd_after5", sd_count - sd0, 1);
        check("restart_step", int'(step), 1);
        do_stop();
        check("restart_queue_empty", exp_q.size(), 0);

        // Stop in the strobe cycle
        cfg_write(0, 2);
        sd0 = sd_count;
        do_start();
        ticks(1, 8);
        tick = 1'b1;
        cycle();
        tick = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (dut.ctr_enable) found = 1'b1;
        end
        check("strobe_enable_seen", int'(found), 1);
        @(posedge clk);
        #1;
        stop = 1'b1;
        @(negedge clk);
        check("strobe_align", int'(dut.ctr_strobe), 1);
        check("strobe_stop_step_done", int'(step_done), 0);
        check("strobe_stop_seq_done", int'(seq_done), 0);
        cycle();
        stop = 1'b0;
        @(negedge clk);
        check("strobe_stop_busy", int'(busy), 0);
        check("strobe_stop_step_held", int'(step), 0);
        check("strobe_stop_no_sd", sd_count - sd0, 0);

        // Configuration: entry 1 written as 0, entry 2 rewritten in step 1
        cfg_table(2, 0, 7, 2);
        push_seq4();
        sd0 = sd_count;
        do_start();
        ticks(2, 8);
        check("cfg_sd_step0", sd_count - sd0, 1);
        ticks(1, 8);
        check("cfg_in_step1", int'(step), 1);
        cfg_write(2, 3);
        ticks(1, 8);
        check("cfg_zero_is_two", sd_count - sd0, 2);
        ticks(2, 8);
        check("cfg_new_not_yet", sd_count - sd0, 2);
        ticks(1, 8);
        check("cfg_new_value_used", sd_count - sd0, 3);
        ticks(2, 8);
        check("cfg_sd_total", sd_count - sd0, 4);
        check("cfg_busy_end", int'(busy), 0);

        // Reset mid-run: table back to 2, outputs to reset values
        cfg_table(4, 4, 4, 4);
        do_start();
        tick = 1'b1;
        repeat (3) cycle();
        tick = 1'b0;
        @(negedge clk);
        check("rstmid_overrun_before", int'(overrun), 1);
        cycle();
        rst = 1'b1;
        cycle();
        @(negedge clk);
        check("rstmid_ctr_rst", int'(dut.ctr_rst), 1);
        cycle();
        rst = 1'b0;
        @(negedge clk);
        check("rstmid_busy", int'(busy), 0);
        check("rstmid_step", int'(step), 0);
        check("rstmid_step_done", int'(step_done), 0);
        check("rstmid_seq_done", int'(seq_done), 0);
        check("rstmid_overrun", int'(overrun), 0);
        push_seq4();
        sd0 = sd_count;
        do_start();
        ticks(2, 8);
        check("rstmid_table_two_step0", sd_count - sd0, 1);
        ticks(6, 8);
        check("rstmid_table_two_all", sd_count - sd0, 4);
        check("rstmid_busy_end", int'(busy), 0);
        check("final_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
